// File: rtl/cpu_defs.sv
// Shared CPU front-end types: virtual addresses and the fetch-queue entry
// handed from the fetch unit to decode.
package cpu_defs;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        virt_t       pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    localparam virt_t RESET_PC_DEFAULT = 32'hbfc0_0000;

endpackage

// File: rtl/cpu_ibus_if.sv
// CPU-side bus of the instruction cache: the fetch unit is master, the
// i$ is slave. flush_1/2/3 kill the corresponding i$ pipeline stages.
interface cpu_ibus_if;
    import cpu_defs::*;

    virt_t       addr;
    logic        read;
    logic        flush_1;
    logic        flush_2;
    logic        flush_3;
    logic        stall;
    logic        ready;
    logic [31:0] rddata;
    logic        rddata_vld;

    modport master (
        output addr, read, flush_1, flush_2, flush_3,
        input  stall, ready, rddata, rddata_vld
    );

    modport slave (
        input  addr, read, flush_1, flush_2, flush_3,
        output stall, ready, rddata, rddata_vld
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, occupancy count and a clear
// that drops all entries; a push in the clearing cycle lands as the only entry.
module sync_fifo #(
    parameter type dtype = logic [31:0],
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  dtype             push_data,
    input  logic             pop,
    output dtype             head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    dtype             mem_q [DEPTH];
    dtype             mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pop frees a slot in the same cycle, so push into a full FIFO is legal alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = push ? PTR_W'(1) : '0;
            count_d  = push ? CNT_W'(1) : '0;
            if (push) mem_d[0] = push_data;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is reset as well so the head reads as all-zero out of reset; the array is small.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues sequential PCs to the i$, pairs returned
// words with their PCs, queues them for decode and flushes everything on redirect.
module inst_fetch_unit
    import cpu_defs::*;
#(
    parameter int    QUEUE_DEPTH  = 8,
    parameter int    INFLIGHT_MAX = 4,
    parameter virt_t RESET_PC     = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    cpu_ibus_if.master        ibus,
    input  logic              redirect_valid,
    input  virt_t             redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output virt_t             inst_pc,
    output logic              inst_adel
);

    localparam int QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int ICW = $clog2(INFLIGHT_MAX + 1);

    virt_t          fetch_pc_q, fetch_pc_d;
    logic           halted_q, halted_d;
    logic [ICW-1:0] inflight_q, inflight_d;

    logic           credit, read, accept, ret, misaligned;
    virt_t          pcf_head;
    logic [ICW-1:0] pcf_count;
    logic           pcf_empty, pcf_full;

    fetch_entry_t   q_push_data, q_head;
    logic [QCW-1:0] q_count;
    logic           q_push, q_pop, q_empty, q_full;

    // Credit counts requests already accepted, so a full queue can never be overrun by returns.
    assign credit = (32'(q_count) + 32'(inflight_q) < 32'(QUEUE_DEPTH)) &&
                    (32'(inflight_q) < 32'(INFLIGHT_MAX));
    assign read       = ibus.ready && credit && !halted_q && !redirect_valid;
    assign accept     = read && !ibus.stall;
    assign ret        = ibus.rddata_vld && !redirect_valid && !pcf_empty;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    assign ibus.addr    = fetch_pc_q;
    assign ibus.read    = read;
    assign ibus.flush_1 = redirect_valid;
    assign ibus.flush_2 = redirect_valid;
    assign ibus.flush_3 = redirect_valid;

    sync_fifo #(.dtype(virt_t), .DEPTH(INFLIGHT_MAX)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (ret),
        .head      (pcf_head),
        .count     (pcf_count),
        .empty     (pcf_empty),
        .full      (pcf_full)
    );

    always_comb begin
        q_push      = ret;
        q_push_data = '{pc: pcf_head, inst: ibus.rddata, adel: 1'b0};
        if (redirect_valid) begin
            // A misaligned target leaves a single error entry behind the clear.
            q_push      = misaligned;
            q_push_data = '{pc: redirect_pc, inst: '0, adel: 1'b1};
        end
    end

    assign q_pop = inst_valid && inst_ready && !redirect_valid;

    sync_fifo #(.dtype(fetch_entry_t), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign inst_valid = !q_empty;
    assign inst       = q_head.inst;
    assign inst_pc    = q_head.pc;
    assign inst_adel  = q_head.adel;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        inflight_d = inflight_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = misaligned;
            inflight_d = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            case ({accept, ret})
                2'b10:   inflight_d = inflight_q + ICW'(1);
                2'b01:   inflight_d = inflight_q - ICW'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            inflight_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ibus.rddata_vld && !redirect_valid && pcf_empty))
                else $error("inst_fetch_unit: rddata_vld with no request outstanding, data dropped");
            assert (!(q_push && q_full && !q_pop && !redirect_valid))
                else $error("inst_fetch_unit: instruction queue overflow");
            assert (!(accept && pcf_full && !ret))
                else $error("inst_fetch_unit: pc fifo overflow");
            assert (inflight_q == pcf_count)
                else $error("inst_fetch_unit: inflight counter out of step with pc fifo");
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 3-cycle, in-order i$ model that can
// inject a 20-cycle miss stall on one address.
module tb_inst_fetch_unit;
    import cpu_defs::*;

    localparam virt_t       RST_PC    = 32'hbfc0_0000;
    localparam virt_t       MISS_ADDR = 32'hbfc0_0020;
    localparam logic [31:0] KEY       = 32'hdead_beef;

    typedef struct {
        virt_t       pc;
        logic [31:0] inst;
        logic        adel;
        int          cyc;
    } pop_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    virt_t       redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    virt_t       inst_pc;
    logic        inst_adel;

    cpu_ibus_if ibus ();

    inst_fetch_unit #(
        .QUEUE_DEPTH  (8),
        .INFLIGHT_MAX (4),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ibus           (ibus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_adel      (inst_adel)
    );

    always #5 clk = ~clk;

    // i$ model: fixed 3-cycle hit latency, flushed as a whole by flush_1.
    logic  miss_armed;
    int    miss_cnt;
    logic  v1, v2, v3;
    virt_t a1, a2, a3;

    assign ibus.stall      = miss_armed && ibus.read && (ibus.addr == MISS_ADDR) && (miss_cnt < 20);
    assign ibus.rddata_vld = v3;
    assign ibus.rddata     = a3 ^ KEY;

    always @(posedge clk) begin
        if (rst || ibus.flush_1) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            a1 <= '0;   a2 <= '0;   a3 <= '0;
        end else begin
            v1 <= ibus.read && !ibus.stall;
            a1 <= ibus.addr;
            v2 <= v1; a2 <= a1;
            v3 <= v2; a3 <= a2;
        end
        if (rst) miss_cnt <= 0;
        else if (ibus.stall) miss_cnt <= miss_cnt + 1;
    end

    // Transaction logs: accepted fetch addresses and entries popped by decode.
    int    cyc = 0;
    virt_t accs[$];
    pop_t  pops[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && ibus.read && !ibus.stall) accs.push_back(ibus.addr);
        if (!rst && !redirect_valid && inst_valid && inst_ready)
            pops.push_back('{inst_pc, inst, inst_adel, cyc});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && pops.size() < n; i++) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input virt_t base, input int n);
        check({tag, "_count"}, 32'(pops.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i < pops.size()) begin
                check($sformatf("%s_pc%0d", tag, i),   pops[i].pc,   base + 32'(4 * i));
                check($sformatf("%s_inst%0d", tag, i), pops[i].inst, (base + 32'(4 * i)) ^ KEY);
                check($sformatf("%s_adel%0d", tag, i), 32'(pops[i].adel), 32'd0);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        accs.delete();
        pops.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        miss_armed     = 1'b0;
        ibus.ready     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_read",    32'(ibus.read),    32'd0);
        check("rst_flush1",  32'(ibus.flush_1), 32'd0);
        check("rst_flush2",  32'(ibus.flush_2), 32'd0);
        check("rst_flush3",  32'(ibus.flush_3), 32'd0);
        check("rst_valid",   32'(inst_valid),   32'd0);
        check("rst_inst",    inst,              32'd0);
        check("rst_pc",      inst_pc,           32'd0);
        check("rst_adel",    32'(inst_adel),    32'd0);
        check("rst_addr",    ibus.addr,         RST_PC);

        // Streaming: i$ becomes ready 5 cycles after reset, decode always ready
        rst        = 1'b0;
        inst_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("notready_read", 32'(ibus.read), 32'd0);
        check("notready_addr", ibus.addr,      RST_PC);
        ibus.ready = 1'b1;
        #1;
        check("first_read", 32'(ibus.read), 32'd1);
        wait_pops(12, 100);
        check("acc0", accs.size() > 0 ? accs[0] : 32'hx, 32'hbfc0_0000);
        check("acc1", accs.size() > 1 ? accs[1] : 32'hx, 32'hbfc0_0004);
        check("first_inst_const", pops.size() > 0 ? pops[0].inst : 32'hx, 32'h616d_beef);
        check_stream("stream", RST_PC, 12);
        if (pops.size() >= 12) check("stream_nogap", 32'(pops[11].cyc - pops[0].cyc), 32'd11);

        // Backpressure: decode stalled, fetch stops at 8 queued+in-flight
        inst_ready = 1'b0;
        reset_dut();
        repeat (30) @(negedge clk);
        check("bp_accepts", 32'(accs.size()), 32'd8);
        check("bp_read",    32'(ibus.read),   32'd0);
        check("bp_valid",   32'(inst_valid),  32'd1);
        check("bp_head_pc", inst_pc,          RST_PC);
        check("bp_addr",    ibus.addr,        32'hbfc0_0020);
        inst_ready = 1'b1;
        wait_pops(10, 100);
        check_stream("bp_drain", RST_PC, 10);

        // Miss stall at 0xbfc00020
        miss_armed = 1'b1;
        reset_dut();
        for (int i = 0; i < 100 && !ibus.stall; i++) @(negedge clk);
        check("miss_stall", 32'(ibus.stall), 32'd1);
        check("miss_addr",  ibus.addr,       MISS_ADDR);
        repeat (10) @(negedge clk);
        check("miss_hold_addr",  ibus.addr,       MISS_ADDR);
        check("miss_hold_read",  32'(ibus.read),  32'd1);
        check("miss_hold_stall", 32'(ibus.stall), 32'd1);
        wait_pops(16, 200);
        check_stream("miss", RST_PC, 16);
        miss_armed = 1'b0;

        // Redirect with 3 in flight and 5 queued, return and decode pop in the same cycle
        inst_ready = 1'b0;
        reset_dut();
        for (int i = 0; i < 100 && accs.size() < 8; i++) @(negedge clk);
        check("rd_pre_accepts", 32'(accs.size()), 32'd8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        inst_ready     = 1'b1;
        #1;
        check("rd_flush1",   32'(ibus.flush_1),    32'd1);
        check("rd_flush2",   32'(ibus.flush_2),    32'd1);
        check("rd_flush3",   32'(ibus.flush_3),    32'd1);
        check("rd_read",     32'(ibus.read),       32'd0);
        check("rd_vld_same", 32'(ibus.rddata_vld), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        pops.delete();
        accs.delete();
        #1;
        check("rd_flush_off", 32'(ibus.flush_1), 32'd0);
        check("rd_empty",     32'(inst_valid),   32'd0);
        check("rd_addr",      ibus.addr,         32'h8000_1000);
        wait_pops(6, 100);
        check_stream("rd", 32'h8000_1000, 6);
        stale = 0;
        foreach (pops[i]) if (pops[i].pc[31:16] == 16'hbfc0) stale++;
        check("rd_no_stale", 32'(stale), 32'd0);

        // Misaligned redirect: single adel entry, fetch halted until the next redirect
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("adel_valid", 32'(inst_valid), 32'd1);
        check("adel_pc",    inst_pc,         32'h8000_1002);
        check("adel_flag",  32'(inst_adel),  32'd1);
        check("adel_inst",  inst,            32'd0);
        check("adel_read",  32'(ibus.read),  32'd0);
        repeat (8) @(negedge clk);
        check("halt_read",  32'(ibus.read),  32'd0);
        check("halt_pc",    inst_pc,         32'h8000_1002);
        pops.delete();
        inst_ready = 1'b1;
        @(negedge clk);
        check("adel_pops",   32'(pops.size()), 32'd1);
        check("adel_popped", 32'(pops.size() > 0 ? pops[0].adel : 1'b0), 32'd1);
        check("adel_drained", 32'(inst_valid), 32'd0);
        check("halt_read2",  32'(ibus.read),   32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        pops.delete();
        wait_pops(4, 100);
        check_stream("unhalt", 32'h8000_2000, 4);

        // fetch_pc wraps from 0xfffffffc to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        @(negedge clk);
        redirect_valid = 1'b0;
        pops.delete();
        accs.delete();
        wait_pops(2, 100);
        check("wrap_pc0",   pops.size() > 0 ? pops[0].pc : 32'hx,   32'hffff_fffc);
        check("wrap_pc1",   pops.size() > 1 ? pops[1].pc : 32'hx,   32'h0000_0000);
        check("wrap_inst1", pops.size() > 1 ? pops[1].inst : 32'hx, 32'hdead_beef);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front-end stage directly upstream of the i$. Generates sequential fetch PCs and drives the i$ CPU bus as master.
- Tracks in-flight requests across the i$ 3-stage pipeline and queues returned instructions with their PCs for decode.
- Handles branch/exception redirects by flushing every i$ stage and all local state in one cycle.

Parameters:
- QUEUE_DEPTH, 8, instruction queue entries (power of 2, ≥4)
- INFLIGHT_MAX, 4, max accepted-but-unreturned i$ requests (power of 2, ≥3)
- RESET_PC, 32'hbfc0_0000, fetch PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ibus  cpu_ibus_if.master  -  i$ bus: drives addr, read, flush_1/2/3; samples stall, ready, rddata, rddata_vld
- redirect_valid  in  1  redirect request from backend
- redirect_pc  in  32  redirect target
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction (0 when adel)
- inst_pc  out  32  head PC
- inst_adel  out  1  head carries address-error-on-fetch

Behaviour:
- Reset values: fetch_pc=RESET_PC; inflight=0; queue empty; halted=0; ibus.read=0; flush_1/2/3=0; inst_valid=0; inst=0; inst_pc=0; inst_adel=0.
- Credit rule:
  - credit = (queue_count + inflight < QUEUE_DEPTH) && (inflight < INFLIGHT_MAX).
  - Counts are registered values (do not include this cycle's returns).
- Issue:
  - ibus.addr = fetch_pc; ibus.read = ibus.ready & credit & ~halted & ~redirect_valid.
  - A request is accepted in a cycle with read=1 and stall=0.
  - On accept: fetch_pc += 4 (32-bit wrap, no carry out); fetch_pc pushed into the pc FIFO; inflight += 1.
  - While stall=1, addr and read are held; no push occurs.
- Return:
  - rddata_vld=1 with redirect_valid=0: pop the pc FIFO; push {pc, rddata, adel=0} into the queue; inflight -= 1.
  - Latency from accept to rddata_vld is ≥3 cycles; the block does not depend on the exact value, only on in-order return.
  - Simultaneous accept and return: inflight unchanged; pc FIFO pushes and pops in the same cycle.
- Decode handshake:
  - inst_valid = queue non-empty. Head pops when inst_valid & inst_ready.
  - Queue push and pop in the same cycle are legal, including when full-after-pop.
  - No bypass: 1-cycle latency from rddata_vld to inst_valid.
- Redirect (redirect_valid=1):
  - Combinationally: flush_1=flush_2=flush_3=1 and ibus.read=0.
  - Any rddata_vld in the same cycle is discarded.
  - Next edge: pc FIFO and queue cleared; inflight=0; fetch_pc=redirect_pc.
  - An inst_ready pop in the same cycle is ignored (queue cleared).
  - Redirect has priority over every other event.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Next edge: queue cleared, then one entry {pc=redirect_pc, inst=0, adel=1} written; halted=1.
  - While halted: read=0, no requests. Only a later redirect clears halted.
  - Redirect while halted behaves as a normal redirect.
- ibus.ready=0 (i$ invalidating after reset): no issue; fetch_pc held.
- Protocol errors (simulation assertions, not recovered in RTL):
  - rddata_vld with empty pc FIFO → drop data.
  - Queue push while full → must never occur; credit guarantees it.
- Reset mid-operation: all state returns to reset values the next edge; in-flight i$ data is not tracked. The i$ is reset by the same rst.

Decomposition:
- Shared package (cpu_defs):
  - virt_t (32b).
  - fetch_entry_t {virt_t pc; logic [31:0] inst; logic adel}.
  - RESET_PC default constant.
- Sub-module sync_fifo (dtype, DEPTH):
  - Registered head, count output, clear input, simultaneous push/pop.
  - Instantiated twice: pc FIFO (virt_t, INFLIGHT_MAX) and instruction queue (fetch_entry_t, QUEUE_DEPTH).
- Top holds the fetch_pc/halted registers, the inflight counter, credit, and redirect logic.

Test Plan:
- Reset, i$ model ready after 5 cycles, always hit, inst_ready=1 → first ibus.addr=0xbfc00000, then 0xbfc00004, …; decode sees inst_pc 0xbfc00000, 0xbfc00004, … in order, no gaps once streaming.
- inst_ready=0 forever, i$ always hit → exactly 8 entries queued; ibus.read drops to 0 when queue_count+inflight=8; no overflow assertion.
- i$ model stalls 20 cycles on a miss at 0xbfc00020 → ibus.addr held at 0xbfc00020; PCs delivered contiguous after stall.
- redirect_pc=0x80001000 while 3 requests are in flight and 5 entries queued → flush_1/2/3 pulse high for 1 cycle; queue empty next cycle; next inst_pc=0x80001000; no stale 0xbfc0xxxx PC appears.
- redirect_pc=0x80001002 → single entry with inst_adel=1, inst_pc=0x80001002; read stays 0 until redirect to 0x80002000, which then fetches normally.
- Redirect, rddata_vld, and inst_ready all asserted in the same cycle → returned data dropped; queue cleared; fetch_pc=target.
